// File: rtl/gpi_irq_pkg.sv
// Shared constants for the GPI interrupt controller: CSR offsets and debounce counter width.
package gpi_irq_pkg;

  localparam logic [1:0] GPI_OFS_IN   = 2'd0;
  localparam logic [1:0] GPI_OFS_IE   = 2'd1;
  localparam logic [1:0] GPI_OFS_IP   = 2'd2;
  localparam logic [1:0] GPI_OFS_EDGE = 2'd3;

  localparam int DB_CNT_W = 4;

endpackage

// File: rtl/gpi_irq_if.sv
// CSR bus between the CPLD bus master and the GPI interrupt controller.
interface gpi_irq_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (output csr_a, output csr_di, output csr_we, input csr_do);
  modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);
endinterface

// File: rtl/gpi_debounce.sv
// One pin: synchronised level -> optional debounce counter -> accepted state flop.
// GPI_IRQ_DEBOUNCE_EN enables the counter; otherwise the state follows the sync output.
module gpi_debounce
  import gpi_irq_pkg::*;
#(
  parameter int DB_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync,
  output logic state,
  output logic change
);

`ifdef GPI_IRQ_DEBOUNCE_EN
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_TICKS - 1);

  logic                sync_q;
  logic [DB_CNT_W-1:0] cnt;
  logic                pend;
  logic                stable;

  assign pend   = sync != state;
  assign stable = sync == sync_q;
  assign change = pend & stable & tick & (cnt == CNT_LAST);

  // Any movement of the sync level restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b0;
      cnt    <= '0;
      state  <= 1'b0;
    end else begin
      sync_q <= sync;
      if (!pend || !stable) begin
        cnt <= '0;
      end else if (change) begin
        cnt   <= '0;
        state <= sync;
      end else if (tick) begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign change      = sync != state;

  always_ff @(posedge clk) begin
    if (rst) state <= 1'b0;
    else     state <= sync;
  end
`endif

endmodule

// File: rtl/gpi_irq.sv
// GPI edge interrupt controller: sync, optional debounce (GPI_IRQ_DEBOUNCE_EN), edge latch, masked level IRQ.
// CSR window of four registers at BASE_ADDR: IN, IE, IP (W1C), EDGE.
module gpi_irq
  import gpi_irq_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR   = 5'h0,
  parameter int         NUM_GPIOS   = 8,
  parameter int         DB_PRESCALE = 256,
  parameter int         DB_TICKS    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gpi_irq_if.slave             bus,
  input  logic [NUM_GPIOS-1:0] in,
  output logic                 irq
);

  logic [NUM_GPIOS-1:0] sync1, sync2, state, change, rise, fall, ev;
  logic [NUM_GPIOS-1:0] ie, ip, edge_sel, wdata;
  logic [1:0]           arm;
  logic [1:0]           ofs;
  logic                 armed, hit, tick;
  logic                 we_ie, we_ip, we_edge;
  logic [7:0]           rdata;

  assign hit     = bus.csr_a[4:2] == BASE_ADDR[4:2];
  assign ofs     = bus.csr_a[1:0];
  assign wdata   = bus.csr_di[NUM_GPIOS-1:0];
  assign armed   = arm == 2'd3;
  assign we_ie   = bus.csr_we & hit & (ofs == GPI_OFS_IE);
  assign we_ip   = bus.csr_we & hit & (ofs == GPI_OFS_IP);
  assign we_edge = bus.csr_we & hit & (ofs == GPI_OFS_EDGE);

`ifdef GPI_IRQ_DEBOUNCE_EN
  localparam int PW = $clog2(DB_PRESCALE);
  logic [PW-1:0] pre_cnt;

  assign tick = pre_cnt == '0;

  always_ff @(posedge clk) begin
    if (rst || tick) pre_cnt <= PW'(DB_PRESCALE - 1);
    else             pre_cnt <= pre_cnt - PW'(1);
  end
`else
  assign tick = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_GPIOS; i++) begin : g_pin
    gpi_debounce #(.DB_TICKS(DB_TICKS)) u_db (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .sync   (sync2[i]),
      .state  (state[i]),
      .change (change[i])
    );
  end

  // Edges are taken from the state flop's update so IP lands on the same clk as IN.
  assign rise = change & ~state;
  assign fall = change & state;
  assign ev   = armed ? ((edge_sel & rise) | (~edge_sel & fall)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      arm      <= 2'd0;
      ie       <= '0;
      ip       <= '0;
      edge_sel <= '0;
      irq      <= 1'b0;
    end else begin
      if (!armed)  arm      <= arm + 2'd1;
      if (we_ie)   ie       <= wdata;
      if (we_edge) edge_sel <= wdata;
      ip  <= (ip & ~(we_ip ? wdata : '0)) | ev;
      irq <= |(ip & ie);
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (ofs)
        GPI_OFS_IN:   rdata[NUM_GPIOS-1:0] = state;
        GPI_OFS_IE:   rdata[NUM_GPIOS-1:0] = ie;
        GPI_OFS_IP:   rdata[NUM_GPIOS-1:0] = ip;
        GPI_OFS_EDGE: rdata[NUM_GPIOS-1:0] = edge_sel;
        default:      rdata = '0;
      endcase
    end
  end

  assign bus.csr_do = rdata;

endmodule

// File: tb/tb_gpi_irq.sv
// Self-checking bench for gpi_irq: directed scenarios plus randomized traffic against a pin-history model.
module tb_gpi_irq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pins = 8'h00;
  logic       irq;

  gpi_irq_if bus_if ();

  gpi_irq #(
    .BASE_ADDR   (5'h0),
    .NUM_GPIOS   (8),
    .DB_PRESCALE (4),
    .DB_TICKS    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave),
    .in  (pins),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: IN is the pin value seen two edges earlier; edges are changes of IN
  // once three clks have passed since reset release.
  logic [7:0] hist[$];
  int         k = 0;
  logic [7:0] m_in = 0, m_ie = 0, m_ip = 0, m_edge = 0;
  logic       m_irq = 0;
  logic [7:0] prev_in, ev, w1c;

  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      hist.delete();
      m_in = 0; m_ie = 0; m_ip = 0; m_edge = 0; m_irq = 0;
    end else begin
      k++;
      hist.push_back(pins);
      prev_in = m_in;
      m_in    = (k >= 3) ? hist[k-3] : 8'h00;
      ev      = (k >= 4) ? ((m_edge & m_in & ~prev_in) | (~m_edge & ~m_in & prev_in)) : 8'h00;
      m_irq   = |(m_ip & m_ie);
      w1c     = 8'h00;
      if (bus_if.csr_we && bus_if.csr_a[4:2] == 3'b000) begin
        case (bus_if.csr_a[1:0])
          2'd1:    m_ie   = bus_if.csr_di;
          2'd2:    w1c    = bus_if.csr_di;
          2'd3:    m_edge = bus_if.csr_di;
          default: ;
        endcase
      end
      m_ip = (m_ip & ~w1c) | ev;
    end
  end

  function automatic logic [7:0] exp_rd(input logic [4:0] a);
    if (a[4:2] != 3'b000) return 8'h00;
    case (a[1:0])
      2'd0:    return m_in;
      2'd1:    return m_ie;
      2'd2:    return m_ip;
      default: return m_edge;
    endcase
  endfunction

`ifndef GPI_IRQ_DEBOUNCE_EN
  always @(negedge clk) begin
    #1;
    check_eq("irq_model", {7'b0, irq}, {7'b0, m_irq});
  end
`endif

  task automatic rd(input logic [4:0] a, input string tag);
    bus_if.csr_a  = a;
    bus_if.csr_we = 1'b0;
    #1;
    check_eq(tag, bus_if.csr_do, exp_rd(a));
  endtask

  task automatic rd_const(input logic [4:0] a, input string tag, input logic [7:0] exp);
    bus_if.csr_a  = a;
    bus_if.csr_we = 1'b0;
    #1;
    check_eq(tag, bus_if.csr_do, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.csr_a  = a;
    bus_if.csr_di = d;
    bus_if.csr_we = 1'b1;
    @(negedge clk);
    bus_if.csr_we = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus_if.csr_a  = 5'h0;
    bus_if.csr_di = 8'h00;
    bus_if.csr_we = 1'b0;

`ifndef GPI_IRQ_DEBOUNCE_EN
    // 1: pins high out of reset give IN but no pending
    pins = 8'hA5;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    rd(5'd0, "t1_in_model");
    rd_const(5'd0, "t1_in", 8'hA5);
    rd_const(5'd2, "t1_ip", 8'h00);
    check_eq("t1_irq", {7'b0, irq}, 8'h00);

    // 2: rising edge on pin 0, latency and W1C
    wr(5'd1, 8'h01);
    wr(5'd3, 8'h01);
    pins[0] = 1'b0;
    wait_clk(4);
    rd_const(5'd2, "t2_ip_pre", 8'h00);
    pins[0] = 1'b1;
    @(negedge clk);
    rd_const(5'd2, "t2_ip_n", 8'h00);
    @(negedge clk);
    rd_const(5'd2, "t2_ip_n1", 8'h00);
    @(negedge clk);
    rd_const(5'd2, "t2_ip_n2", 8'h01);
    check_eq("t2_irq_n2", {7'b0, irq}, 8'h00);
    @(negedge clk);
    check_eq("t2_irq_n3", {7'b0, irq}, 8'h01);
    wr(5'd2, 8'h01);
    rd_const(5'd2, "t2_ip_clr", 8'h00);
    @(negedge clk);
    check_eq("t2_irq_clr", {7'b0, irq}, 8'h00);

    // 3: falling edge on pin 3 with IE off
    wr(5'd1, 8'h00);
    wr(5'd3, 8'h00);
    pins[3] = 1'b1;
    wait_clk(4);
    rd_const(5'd2, "t3_ip_rise_ign", 8'h00);
    pins[3] = 1'b0;
    wait_clk(4);
    rd_const(5'd2, "t3_ip_fall", 8'h08);
    pins[3] = 1'b1;
    wait_clk(4);
    rd_const(5'd2, "t3_ip_hold", 8'h08);
    check_eq("t3_irq", {7'b0, irq}, 8'h00);

    // 4: edge and W1C of the same bit in one clk
    wr(5'd3, 8'h04);
    wr(5'd2, 8'hFF);
    pins[2] = 1'b0;
    wait_clk(4);
    pins[2] = 1'b1;
    wait_clk(4);
    rd_const(5'd2, "t4_ip_set", 8'h04);
    pins[2] = 1'b0;
    wait_clk(4);
    pins[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_if.csr_a  = 5'd2;
    bus_if.csr_di = 8'h04;
    bus_if.csr_we = 1'b1;
    @(negedge clk);
    bus_if.csr_we = 1'b0;
    rd_const(5'd2, "t4_edge_wins", 8'h04);

    // 5: IE set on an already pending bit; write to IN ignored
    wr(5'd2, 8'hFF);
    wr(5'd1, 8'h00);
    wr(5'd3, 8'h10);
    pins[4] = 1'b1;
    wait_clk(5);
    rd_const(5'd2, "t5_ip", 8'h10);
    check_eq("t5_irq_pre", {7'b0, irq}, 8'h00);
    wr(5'd1, 8'h10);
    check_eq("t5_irq_w", {7'b0, irq}, 8'h00);
    @(negedge clk);
    check_eq("t5_irq_w1", {7'b0, irq}, 8'h01);
    wr(5'd0, 8'hFF);
    rd(5'd0, "t5_in_ro");
    rd_const(5'd8, "t5_unmapped", 8'h00);

    // Randomized traffic including mid-run resets and out-of-map accesses
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 5) == 0) pins = pins ^ (8'h01 << $urandom_range(0, 7));
      bus_if.csr_a  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      bus_if.csr_di = 8'($urandom());
      bus_if.csr_we = ($urandom_range(0, 2) == 0);
      #1;
      check_eq("rnd_rd", bus_if.csr_do, exp_rd(bus_if.csr_a));
    end
    @(negedge clk);
    rst           = 1'b0;
    bus_if.csr_we = 1'b0;
    wait_clk(2);
`else
    // 6: debounce with DB_PRESCALE=4, DB_TICKS=4
    pins = 8'h00;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    wr(5'd3, 8'h01);
    wr(5'd1, 8'h01);
    pins[0] = 1'b1;
    wait_clk(10);
    pins[0] = 1'b0;
    wait_clk(40);
    rd_const(5'd2, "t6_short_pulse", 8'h00);
    rd_const(5'd0, "t6_short_in", 8'h00);
    pins[0] = 1'b1;
    wait_clk(40);
    rd_const(5'd0, "t6_long_in", 8'h01);
    pins[0] = 1'b0;
    wait_clk(40);
    rd_const(5'd2, "t6_long_pulse", 8'h01);
    check_eq("t6_irq", {7'b0, irq}, 8'h01);
    wr(5'd2, 8'h01);
    pins[0] = 1'b1;
    wait_clk(10);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(5);
    rd_const(5'd2, "t6_rst_ip", 8'h00);
    rd_const(5'd0, "t6_rst_in", 8'h00);
    check_eq("t6_rst_irq", {7'b0, irq}, 8'h00);
    pins[0] = 1'b0;
    wait_clk(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
